alu_multicycle: RTL and testbench

Parametrised successor to the single-cycle datapath ALU. It keeps the same funct-code op set (AND/OR/ADD/SUB/SLT) as registered single-cycle ops. It adds iterative unsigned multiply and divide into internal HI/LO registers, plus MFHI/MFLO readback, under a start/busy/done handshake. It sits in the EX stage; the hazard unit stalls the pipeline while busy is high.

---
 rtl/alu_multicycle.sv | 216 +++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// EX-stage ALU: registered single-cycle logic/arith ops plus iterative unsigned
// multiply/divide into HI/LO, with a start/busy/done handshake.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] dout_r, dout_nxt_s;
    logic [WIDTH-1:0] hi_r, hi_nxt_s;
    logic [WIDTH-1:0] lo_r, lo_nxt_s;
    logic             done_r, done_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic [WIDTH-1:0] work_hi_r, work_hi_nxt_s;
    logic [WIDTH-1:0] work_lo_r, work_lo_nxt_s;
    logic [WIDTH-1:0] opnd_r, opnd_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;

    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] single_res_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_s, mul_lo_s;
    logic [WIDTH:0]   div_shift_s, div_diff_s;
    logic [WIDTH-1:0] div_hi_s, div_lo_s;

    assign accept_s = start && (state_r == S_IDLE);
    assign last_s   = (cnt_r == CNT_LAST);

    // Multiply step: conditionally add multiplicand to the upper half, then shift the pair right.
    assign mul_sum_s = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign mul_hi_s  = mul_sum_s[WIDTH:1];
    assign mul_lo_s  = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};

    // Divide step: remainder:dividend shift left, trial subtract, restore when it borrows.
    assign div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
    assign div_hi_s    = div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
    assign div_lo_s    = {work_lo_r[WIDTH-2:0], ~div_diff_s[WIDTH]};

    // Single-cycle result selection from the current funct code and operands.
    always_comb begin
        single_res_s = {WIDTH{1'b0}};
        case (Signal)
            F_AND:   single_res_s = dataA & dataB;
            F_OR:    single_res_s = dataA | dataB;
            F_ADD:   single_res_s = dataA + dataB;
            F_SUB:   single_res_s = dataA - dataB;
            F_SLT:   single_res_s = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            F_MFHI:  single_res_s = hi_r;
            F_MFLO:  single_res_s = lo_r;
            default: single_res_s = {WIDTH{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero divisor completes in IDLE without iterating.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && (Signal == F_MULTU)) begin
                    state_nxt_s = S_MUL;
                end else if (accept_s && (Signal == F_DIVU) && (dataB != {WIDTH{1'b0}})) begin
                    state_nxt_s = S_DIV;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MUL:   state_nxt_s = last_s ? S_IDLE : S_MUL;
            S_DIV:   state_nxt_s = last_s ? S_IDLE : S_DIV;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output/datapath logic; HI/LO are only written on completion, never mid-iteration.
    always_comb begin
        dout_nxt_s    = dout_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        done_nxt_s    = 1'b0;
        work_hi_nxt_s = work_hi_r;
        work_lo_nxt_s = work_lo_r;
        opnd_nxt_s    = opnd_r;
        cnt_nxt_s     = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (Signal == F_MULTU) begin
                        work_hi_nxt_s = {WIDTH{1'b0}};
                        work_lo_nxt_s = dataB;
                        opnd_nxt_s    = dataA;
                        cnt_nxt_s     = {CW{1'b0}};
                    end else if (Signal == F_DIVU) begin
                        if (dataB == {WIDTH{1'b0}}) begin
                            lo_nxt_s   = {WIDTH{1'b1}};
                            hi_nxt_s   = dataA;
                            dout_nxt_s = {WIDTH{1'b1}};
                            done_nxt_s = 1'b1;
                        end else begin
                            work_hi_nxt_s = {WIDTH{1'b0}};
                            work_lo_nxt_s = dataA;
                            opnd_nxt_s    = dataB;
                            cnt_nxt_s     = {CW{1'b0}};
                        end
                    end else begin
                        dout_nxt_s = single_res_s;
                        done_nxt_s = 1'b1;
                    end
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            S_MUL: begin
                work_hi_nxt_s = mul_hi_s;
                work_lo_nxt_s = mul_lo_s;
                cnt_nxt_s     = cnt_r + CW'(1);
                if (last_s) begin
                    hi_nxt_s   = mul_hi_s;
                    lo_nxt_s   = mul_lo_s;
                    dout_nxt_s = mul_lo_s;
                    done_nxt_s = 1'b1;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            S_DIV: begin
                work_hi_nxt_s = div_hi_s;
                work_lo_nxt_s = div_lo_s;
                cnt_nxt_s     = cnt_r + CW'(1);
                if (last_s) begin
                    hi_nxt_s   = div_hi_s;
                    lo_nxt_s   = div_lo_s;
                    dout_nxt_s = div_lo_s;
                    done_nxt_s = 1'b1;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            default: begin
                done_nxt_s = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != S_IDLE);
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r    <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            work_hi_r <= {WIDTH{1'b0}};
            work_lo_r <= {WIDTH{1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
        end else begin
            dout_r    <= dout_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= busy_nxt_s;
            work_hi_r <= work_hi_nxt_s;
            work_lo_r <= work_lo_nxt_s;
            opnd_r    <= opnd_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign dataOut = dout_r;
    assign done    = done_r;
    assign busy    = busy_r;
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a 32-bit and an 8-bit instance checked against an
// arithmetic reference model with directed and randomized operations.
module tb_alu_multicycle;

    localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MFLO = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start8;
    logic [5:0]  Signal;
    logic [31:0] dataA, dataB;
    logic [31:0] dout32, hi32, lo32;
    logic [7:0]  dout8, hi8, lo8;
    logic        done32, busy32, done8, busy8;

    int checks = 0;
    int errors = 0;
    logic [63:0] mhi32, mlo32, mhi8, mlo8;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .dataOut(dout32), .done(done32),
        .busy(busy32), .hi(hi32), .lo(lo32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .Signal(Signal),
        .dataA(dataA[7:0]), .dataB(dataB[7:0]), .dataOut(dout8), .done(done8),
        .busy(busy8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_dout(input bit u);
        return u ? {56'd0, dout8} : {32'd0, dout32};
    endfunction
    function automatic logic [63:0] get_hi(input bit u);
        return u ? {56'd0, hi8} : {32'd0, hi32};
    endfunction
    function automatic logic [63:0] get_lo(input bit u);
        return u ? {56'd0, lo8} : {32'd0, lo32};
    endfunction
    function automatic logic get_done(input bit u);
        return u ? done8 : done32;
    endfunction
    function automatic logic get_busy(input bit u);
        return u ? busy8 : busy32;
    endfunction

    // Reference model: plain arithmetic on w-bit values held in 64-bit containers.
    task automatic model(input logic [5:0] f, input logic [63:0] ai, input logic [63:0] bi,
                         input int w, inout logic [63:0] mh, inout logic [63:0] ml,
                         output logic [63:0] dout, output int lat);
        logic [63:0] mask, a, b, p;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = ai & mask;
        b = bi & mask;
        sa = longint'(a) - (a[w-1] ? (longint'(1) << w) : longint'(0));
        sb = longint'(b) - (b[w-1] ? (longint'(1) << w) : longint'(0));
        lat = 0;
        case (f)
            F_AND:  dout = a & b;
            F_OR:   dout = a | b;
            F_ADD:  dout = (a + b) & mask;
            F_SUB:  dout = (a - b) & mask;
            F_SLT:  dout = (sa < sb) ? 64'd1 : 64'd0;
            F_MFHI: dout = mh;
            F_MFLO: dout = ml;
            F_MULTU: begin
                p = a * b;
                mh = p >> w;
                ml = p & mask;
                dout = ml;
                lat = w;
            end
            F_DIVU: begin
                if (b == 64'd0) begin
                    ml = mask;
                    mh = a;
                end else begin
                    ml = a / b;
                    mh = a % b;
                    lat = w;
                end
                dout = ml;
            end
            default: dout = 64'd0;
        endcase
    endtask

    // Issues one op at the current falling edge and checks latency, busy time and results.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit use8, input string tag);
        int w, lat_m, lat_o, busy_o;
        logic [63:0] hm, lm, dm;
        w = use8 ? 8 : 32;
        hm = use8 ? mhi8 : mhi32;
        lm = use8 ? mlo8 : mlo32;
        model(f, {32'd0, a}, {32'd0, b}, w, hm, lm, dm, lat_m);
        Signal = f;
        dataA = a;
        dataB = b;
        if (use8) start8 = 1'b1; else start32 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        start32 = 1'b0;
        Signal = 6'($urandom);
        dataA = $urandom;
        dataB = $urandom;
        lat_o = 0;
        busy_o = 0;
        while (get_done(use8) !== 1'b1 && lat_o < 40) begin
            if (get_busy(use8) === 1'b1) busy_o++;
            @(negedge clk);
            lat_o++;
        end
        check({tag, " latency"}, 64'(lat_o), 64'(lat_m));
        check({tag, " busy_cycles"}, 64'(busy_o), 64'(lat_m));
        check({tag, " dataOut"}, get_dout(use8), dm);
        check({tag, " hi"}, get_hi(use8), hm);
        check({tag, " lo"}, get_lo(use8), lm);
        if (use8) begin mhi8 = hm; mlo8 = lm; end
        else begin mhi32 = hm; mlo32 = lm; end
        @(negedge clk);
        check({tag, " done_pulse"}, {63'd0, get_done(use8)}, 64'd0);
        check({tag, " dataOut_hold"}, get_dout(use8), dm);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without an edge.
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, " dout32"}, {32'd0, dout32}, 64'd0);
        check({tag, " hi32"}, {32'd0, hi32}, 64'd0);
        check({tag, " lo32"}, {32'd0, lo32}, 64'd0);
        check({tag, " done_busy32"}, {62'd0, done32, busy32}, 64'd0);
        check({tag, " all8"}, {38'd0, dout8, hi8, lo8, done8, busy8}, 64'd0);
        mhi32 = 64'd0; mlo32 = 64'd0; mhi8 = 64'd0; mlo8 = 64'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0]  ops [10];
        logic [5:0]  f;
        logic [63:0] hm, lm, dm;
        int          lat, n;
        logic [31:0] a, b;
        ops = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_MULTU, F_DIVU, F_MFHI, F_MFLO, 6'b111111};

        reset = 1'b1;
        start32 = 1'b0;
        start8 = 1'b0;
        Signal = 6'd0;
        dataA = 32'd0;
        dataB = 32'd0;
        mhi32 = 64'd0; mlo32 = 64'd0; mhi8 = 64'd0; mlo8 = 64'd0;
        repeat (2) @(negedge clk);
        check("por dout32", {32'd0, dout32}, 64'd0);
        check("por busy32", {63'd0, busy32}, 64'd0);
        reset = 1'b0;

        do_op(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
        do_op(F_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, "sub_wrap");
        do_op(F_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "slt_ovf");
        do_op(F_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "slt_pos_neg");
        do_op(F_SLT, 32'h0000_0005, 32'h0000_0005, 1'b0, "slt_eq");
        do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_max");
        check("mul_max hi_const", {32'd0, hi32}, 64'h0000_0000_FFFF_FFFE);
        do_op(F_MFHI, 32'd0, 32'd0, 1'b0, "mfhi");
        do_op(F_DIVU, 32'd100, 32'd7, 1'b0, "div_100_7");
        check("div_100_7 lo_const", {32'd0, lo32}, 64'd14);
        do_op(F_DIVU, 32'd5, 32'd0, 1'b0, "div_by_zero");
        reset_pulse("rst_idle");

        do_op(F_MULTU, 32'h0000_00FF, 32'h0000_00FF, 1'b1, "mul8_max");
        do_op(F_DIVU, 32'h0000_00C8, 32'h0000_000A, 1'b1, "div8");
        do_op(F_DIVU, 32'h0000_0033, 32'h0000_0000, 1'b1, "div8_zero");

        // Back-to-back single-cycle ops: done stays high, one result per cycle.
        dm = 64'd0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                check("b2b done", {63'd0, done32}, 64'd1);
                check("b2b dataOut", {32'd0, dout32}, dm);
            end
            if (i < 4) begin
                f = ops[$urandom_range(0, 4)];
                a = rnd_val();
                b = rnd_val();
                hm = mhi32; lm = mlo32;
                model(f, {32'd0, a}, {32'd0, b}, 32, hm, lm, dm, lat);
                Signal = f; dataA = a; dataB = b; start32 = 1'b1;
            end else begin
                start32 = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b done_fall", {63'd0, done32}, 64'd0);

        // Start held high with ADD during a multiply must be ignored.
        hm = mhi32; lm = mlo32;
        model(F_MULTU, 64'h1234_5678, 64'h9ABC_DEF0, 32, hm, lm, dm, lat);
        Signal = F_MULTU; dataA = 32'h1234_5678; dataB = 32'h9ABC_DEF0; start32 = 1'b1;
        @(negedge clk);
        Signal = F_ADD; dataA = 32'd2; dataB = 32'd3;
        n = 0;
        while (done32 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        start32 = 1'b0;
        check("ign latency", 64'(n), 64'd32);
        check("ign dataOut", {32'd0, dout32}, dm);
        check("ign hi", {32'd0, hi32}, hm);
        mhi32 = hm; mlo32 = lm;
        @(negedge clk);
        check("ign done_fall", {63'd0, done32}, 64'd0);
        check("ign dataOut_hold", {32'd0, dout32}, dm);

        // Reset in the middle of a multiply.
        Signal = F_MULTU; dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        check("mid busy", {63'd0, busy32}, 64'd1);
        reset_pulse("rst_mid_mul");
        do_op(F_ADD, 32'd2, 32'd3, 1'b0, "add_after_rst");

        for (int i = 0; i < 30; i++) begin
            f = ops[$urandom_range(0, 9)];
            a = rnd_val();
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : rnd_val();
            do_op(f, a, b, 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
